// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter
// Shares one single-port BRAM port between instruction fetch (IF) and the
// load/store unit (DM). The BRAM has a 1-cycle read latency. Arbitration is
// round-robin.
//
// Each side has the following:
//   - A valid/ready request channel.
//   - A valid/ready response channel with a one-entry hold register, which
//     keeps an unaccepted read response stable until the consumer takes it.
//
// IF also has a flush input that drops stale fetch responses.
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   if_req_valid_i/ready_o, if_addr_i fetch request channel
//   if_flush_i                        drop older fetch responses
//   if_rsp_valid_o/data_o/ready_i     fetch response channel
//   dm_req_valid_i/ready_o, dm_addr_i data request channel
//   dm_we_i, dm_wstrb_i, dm_wdata_i   write control / byte enables / data
//   dm_rsp_valid_o/data_o/ready_i     load response channel
//   mem_en_o, mem_we_o, mem_addr_o,
//   mem_wdata_o, mem_rdata_i          BRAM port (read data one cycle after enable)
module imem_dmem_arbiter #(
  parameter int XLEN   = 32,
  parameter int STRB_W = XLEN / 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_valid_i,
  output logic              if_req_ready_o,
  input  logic [XLEN-1:0]   if_addr_i,
  input  logic              if_flush_i,
  output logic              if_rsp_valid_o,
  output logic [XLEN-1:0]   if_rsp_data_o,
  input  logic              if_rsp_ready_i,
  input  logic              dm_req_valid_i,
  output logic              dm_req_ready_o,
  input  logic [XLEN-1:0]   dm_addr_i,
  input  logic              dm_we_i,
  input  logic [STRB_W-1:0] dm_wstrb_i,
  input  logic [XLEN-1:0]   dm_wdata_i,
  output logic              dm_rsp_valid_o,
  output logic [XLEN-1:0]   dm_rsp_data_o,
  input  logic              dm_rsp_ready_i,
  output logic              mem_en_o,
  output logic [STRB_W-1:0] mem_we_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic [XLEN-1:0]   mem_rdata_i
);

  typedef enum logic {GNT_IF = 1'b0, GNT_DM = 1'b1} grant_e;

  grant_e            last_grant_r;
  logic              if_inflight_r;
  logic              if_hold_valid_r;
  logic [XLEN-1:0]   if_hold_data_r;
  logic              dm_inflight_r;
  logic              dm_hold_valid_r;
  logic [XLEN-1:0]   dm_hold_data_r;

  logic              if_rsp_valid_s;
  logic [XLEN-1:0]   if_rsp_data_s;
  logic              dm_rsp_valid_s;
  logic [XLEN-1:0]   dm_rsp_data_s;
  logic              if_elig_s;
  logic              dm_elig_s;
  logic              if_grant_s;
  logic              dm_grant_s;

  // Response presentation. Live BRAM data is used in the cycle after the
  // grant; after that, the captured copy in the hold register is used.
  // Flush hides any IF response in the cycle it is asserted.
  always_comb begin
    if_rsp_valid_s = 1'b0;
    dm_rsp_valid_s = 1'b0;
    if_rsp_data_s  = mem_rdata_i;
    dm_rsp_data_s  = mem_rdata_i;
    if (rst_i || if_flush_i) begin
      if_rsp_valid_s = 1'b0;
    end else begin
      if_rsp_valid_s = if_inflight_r | if_hold_valid_r;
    end
    if (rst_i) begin
      dm_rsp_valid_s = 1'b0;
    end else begin
      dm_rsp_valid_s = dm_inflight_r | dm_hold_valid_r;
    end
    if (if_hold_valid_r) begin
      if_rsp_data_s = if_hold_data_r;
    end else begin
      if_rsp_data_s = mem_rdata_i;
    end
    if (dm_hold_valid_r) begin
      dm_rsp_data_s = dm_hold_data_r;
    end else begin
      dm_rsp_data_s = mem_rdata_i;
    end
  end

  // Eligibility and round-robin grant. A port whose response would still be
  // pending next cycle is not eligible, so each port has at most one read
  // outstanding.
  always_comb begin
    if_elig_s  = if_req_valid_i & (~if_rsp_valid_s | if_rsp_ready_i) & ~rst_i;
    dm_elig_s  = dm_req_valid_i & (~dm_rsp_valid_s | dm_rsp_ready_i) & ~rst_i;
    if_grant_s = 1'b0;
    dm_grant_s = 1'b0;
    if (if_elig_s && dm_elig_s) begin
      if (last_grant_r == GNT_DM) begin
        if_grant_s = 1'b1;
      end else begin
        dm_grant_s = 1'b1;
      end
    end else begin
      if_grant_s = if_elig_s;
      dm_grant_s = dm_elig_s;
    end
  end

  // BRAM port drive. The address is passed through unregistered because the
  // BRAM wrapper registers it.
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = {STRB_W{1'b0}};
    mem_addr_o  = {XLEN{1'b0}};
    mem_wdata_o = {XLEN{1'b0}};
    if (if_grant_s) begin
      mem_en_o   = 1'b1;
      mem_addr_o = if_addr_i;
    end else if (dm_grant_s) begin
      mem_en_o   = 1'b1;
      mem_addr_o = dm_addr_i;
      if (dm_we_i) begin
        mem_we_o    = dm_wstrb_i;
        mem_wdata_o = dm_wdata_i;
      end else begin
        mem_we_o    = {STRB_W{1'b0}};
        mem_wdata_o = {XLEN{1'b0}};
      end
    end else begin
      mem_en_o = 1'b0;
    end
  end

  assign if_req_ready_o = if_grant_s;
  assign dm_req_ready_o = dm_grant_s;
  assign if_rsp_valid_o = if_rsp_valid_s;
  assign if_rsp_data_o  = if_rsp_data_s;
  assign dm_rsp_valid_o = dm_rsp_valid_s;
  assign dm_rsp_data_o  = dm_rsp_data_s;

  // State update: last grant, in-flight reads and response hold registers.
  // Each in-flight flag is reloaded from this cycle's grant. As a result, a
  // fetch accepted during a flush survives, while the older in-flight read
  // is dropped. An unaccepted valid response is copied into the hold
  // register. A flush makes the IF response invalid, so a held response is
  // released.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant_r    <= GNT_DM;
      if_inflight_r   <= 1'b0;
      if_hold_valid_r <= 1'b0;
      if_hold_data_r  <= {XLEN{1'b0}};
      dm_inflight_r   <= 1'b0;
      dm_hold_valid_r <= 1'b0;
      dm_hold_data_r  <= {XLEN{1'b0}};
    end else begin
      if (if_grant_s) begin
        last_grant_r <= GNT_IF;
      end else if (dm_grant_s) begin
        last_grant_r <= GNT_DM;
      end else begin
        last_grant_r <= last_grant_r;
      end
      if_inflight_r <= if_grant_s;
      dm_inflight_r <= dm_grant_s & ~dm_we_i;
      if (if_rsp_valid_s && !if_rsp_ready_i) begin
        if_hold_valid_r <= 1'b1;
        if_hold_data_r  <= if_rsp_data_s;
      end else begin
        if_hold_valid_r <= 1'b0;
        if_hold_data_r  <= if_hold_data_r;
      end
      if (dm_rsp_valid_s && !dm_rsp_ready_i) begin
        dm_hold_valid_r <= 1'b1;
        dm_hold_data_r  <= dm_rsp_data_s;
      end else begin
        dm_hold_valid_r <= 1'b0;
        dm_hold_data_r  <= dm_hold_data_r;
      end
    end
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Testbench for imem_dmem_arbiter. A behavioural BRAM with 1-cycle read
// latency sits on the memory port. The stimulus process drives directed
// vectors and pushes hand-computed read data into per-port queues. A monitor
// pops and compares whenever a response handshake occurs.
module tb_imem_dmem_arbiter;
  localparam int XLEN   = 32;
  localparam int STRB_W = 4;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              if_req_valid_i;
  logic              if_req_ready_o;
  logic [XLEN-1:0]   if_addr_i;
  logic              if_flush_i;
  logic              if_rsp_valid_o;
  logic [XLEN-1:0]   if_rsp_data_o;
  logic              if_rsp_ready_i;
  logic              dm_req_valid_i;
  logic              dm_req_ready_o;
  logic [XLEN-1:0]   dm_addr_i;
  logic              dm_we_i;
  logic [STRB_W-1:0] dm_wstrb_i;
  logic [XLEN-1:0]   dm_wdata_i;
  logic              dm_rsp_valid_o;
  logic [XLEN-1:0]   dm_rsp_data_o;
  logic              dm_rsp_ready_i;
  logic              mem_en_o;
  logic [STRB_W-1:0] mem_we_o;
  logic [XLEN-1:0]   mem_addr_o;
  logic [XLEN-1:0]   mem_wdata_o;
  logic [XLEN-1:0]   mem_rdata_i;

  int checks = 0;
  int errors = 0;
  logic [XLEN-1:0] exp_if[$];
  logic [XLEN-1:0] exp_dm[$];

  imem_dmem_arbiter #(.XLEN(XLEN), .STRB_W(STRB_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_valid_i(if_req_valid_i), .if_req_ready_o(if_req_ready_o),
    .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_rsp_valid_o(if_rsp_valid_o), .if_rsp_data_o(if_rsp_data_o),
    .if_rsp_ready_i(if_rsp_ready_i),
    .dm_req_valid_i(dm_req_valid_i), .dm_req_ready_o(dm_req_ready_o),
    .dm_addr_i(dm_addr_i), .dm_we_i(dm_we_i), .dm_wstrb_i(dm_wstrb_i),
    .dm_wdata_i(dm_wdata_i),
    .dm_rsp_valid_o(dm_rsp_valid_o), .dm_rsp_data_o(dm_rsp_data_o),
    .dm_rsp_ready_i(dm_rsp_ready_i),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural BRAM: read-first, registered read data, byte write enables.
  // Known contents are loaded while reset is held.
  logic [XLEN-1:0] mem [0:1023];
  logic [XLEN-1:0] wword;
  always @(posedge clk_i) begin
    if (rst_i) begin
      mem[0]      <= 32'h0000_0011;
      mem[1]      <= 32'h0000_0022;
      mem[2]      <= 32'h0000_0033;
      mem[3]      <= 32'h0000_0044;
      mem[16]     <= 32'hDEAD_BEEF;
      mem[17]     <= 32'h0000_0055;
      mem[64]     <= 32'h0000_0000;
      mem[128]    <= 32'hCAFE_0200;
      mem_rdata_i <= 32'h0;
    end else if (mem_en_o) begin
      wword = mem[mem_addr_o[11:2]];
      for (int b = 0; b < STRB_W; b++) begin
        if (mem_we_o[b]) wword[8*b +: 8] = mem_wdata_o[8*b +: 8];
      end
      mem[mem_addr_o[11:2]] <= wword;
      mem_rdata_i <= mem[mem_addr_o[11:2]];
    end
  end

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every response handshake must match the oldest
  // expected word for that port.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (if_rsp_valid_o && if_rsp_ready_i) begin
        if (exp_if.size() == 0) chk32("if_rsp_unexpected", if_rsp_data_o, 32'hXXXX_XXXX);
        else chk32("if_rsp_data", if_rsp_data_o, exp_if.pop_front());
      end
      if (dm_rsp_valid_o && dm_rsp_ready_i) begin
        if (exp_dm.size() == 0) chk32("dm_rsp_unexpected", dm_rsp_data_o, 32'hXXXX_XXXX);
        else chk32("dm_rsp_data", dm_rsp_data_o, exp_dm.pop_front());
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    if_req_valid_i = 1'b0;
    dm_req_valid_i = 1'b0;
    dm_we_i        = 1'b0;
    if_flush_i     = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    if_req_valid_i = 1'b0; if_addr_i = 32'h0; if_flush_i = 1'b0; if_rsp_ready_i = 1'b1;
    dm_req_valid_i = 1'b0; dm_addr_i = 32'h0; dm_we_i = 1'b0; dm_wstrb_i = 4'h0;
    dm_wdata_i = 32'h0; dm_rsp_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Reset state
    @(negedge clk_i);
    chk1("rst_if_rsp_valid", if_rsp_valid_o, 1'b0);
    chk1("rst_dm_rsp_valid", dm_rsp_valid_o, 1'b0);
    chk1("rst_mem_en", mem_en_o, 1'b0);
    chk32("rst_mem_we", {28'h0, mem_we_o}, 32'h0);
    next_cycle();

    // Contention from reset: IF wins the first tie, then alternation
    for (int i = 0; i < 4; i++) begin
      if_req_valid_i = 1'b1; if_addr_i = (i < 2) ? 32'h0 : 32'h4;
      dm_req_valid_i = 1'b1; dm_addr_i = (i < 2) ? 32'h8 : 32'hC;
      @(negedge clk_i);
      chk1("cont_if_grant", if_req_ready_o, (i % 2 == 0));
      chk1("cont_dm_grant", dm_req_ready_o, (i % 2 == 1));
      if (i == 0) exp_if.push_back(32'h11);
      if (i == 1) exp_dm.push_back(32'h33);
      if (i == 2) exp_if.push_back(32'h22);
      if (i == 3) exp_dm.push_back(32'h44);
      next_cycle();
    end
    idle();
    next_cycle();

    // IF only, back-to-back at full throughput
    for (int i = 0; i < 3; i++) begin
      if_req_valid_i = 1'b1; if_addr_i = 32'h4 * i;
      @(negedge clk_i);
      chk1("ifonly_ready", if_req_ready_o, 1'b1);
      if (i == 0) exp_if.push_back(32'h11);
      if (i == 1) exp_if.push_back(32'h22);
      if (i == 2) exp_if.push_back(32'h33);
      next_cycle();
    end
    idle();
    next_cycle();

    // Backpressure: response held stable for 3 stalled cycles
    if_req_valid_i = 1'b1; if_addr_i = 32'h40; if_rsp_ready_i = 1'b1;
    @(negedge clk_i);
    chk1("bp_first_ready", if_req_ready_o, 1'b1);
    exp_if.push_back(32'hDEAD_BEEF);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      if_addr_i = 32'h44; if_rsp_ready_i = 1'b0;
      @(negedge clk_i);
      chk1("bp_stall_ready", if_req_ready_o, 1'b0);
      chk1("bp_stall_valid", if_rsp_valid_o, 1'b1);
      chk32("bp_stall_data", if_rsp_data_o, 32'hDEAD_BEEF);
      next_cycle();
    end
    if_rsp_ready_i = 1'b1;
    @(negedge clk_i);
    chk1("bp_accept_valid", if_rsp_valid_o, 1'b1);
    chk1("bp_accept_ready", if_req_ready_o, 1'b1);
    exp_if.push_back(32'h55);
    next_cycle();
    idle();
    next_cycle();

    // DM write with partial strobe, zero-strobe write, then read back
    dm_req_valid_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h100;
    dm_wdata_i = 32'hAABB_CCDD; dm_wstrb_i = 4'b0101;
    @(negedge clk_i);
    chk1("wr_ready", dm_req_ready_o, 1'b1);
    chk1("wr_mem_en", mem_en_o, 1'b1);
    chk32("wr_mem_we", {28'h0, mem_we_o}, 32'h5);
    chk32("wr_mem_addr", mem_addr_o, 32'h100);
    chk32("wr_mem_wdata", mem_wdata_o, 32'hAABB_CCDD);
    next_cycle();
    dm_wdata_i = 32'hFFFF_FFFF; dm_wstrb_i = 4'b0000;
    @(negedge clk_i);
    chk1("wr0_ready", dm_req_ready_o, 1'b1);
    chk1("wr0_mem_en", mem_en_o, 1'b1);
    chk32("wr0_mem_we", {28'h0, mem_we_o}, 32'h0);
    chk1("wr_no_rsp", dm_rsp_valid_o, 1'b0);
    next_cycle();
    dm_we_i = 1'b0;
    @(negedge clk_i);
    chk1("rd_ready", dm_req_ready_o, 1'b1);
    chk32("rd_mem_we", {28'h0, mem_we_o}, 32'h0);
    chk1("wr0_no_rsp", dm_rsp_valid_o, 1'b0);
    exp_dm.push_back(32'h00BB_00DD);
    next_cycle();
    idle();
    next_cycle();

    // Flush: in-flight 0x8 dropped, 0x200 accepted in the flush cycle survives
    if_req_valid_i = 1'b1; if_addr_i = 32'h8;
    @(negedge clk_i);
    chk1("fl_old_ready", if_req_ready_o, 1'b1);
    next_cycle();
    if_addr_i = 32'h200; if_flush_i = 1'b1;
    @(negedge clk_i);
    chk1("fl_rsp_hidden", if_rsp_valid_o, 1'b0);
    chk1("fl_new_ready", if_req_ready_o, 1'b1);
    exp_if.push_back(32'hCAFE_0200);
    next_cycle();
    idle();
    @(negedge clk_i);
    chk1("fl_new_rsp", if_rsp_valid_o, 1'b1);
    next_cycle();

    // Flush also discards a held IF response
    if_req_valid_i = 1'b1; if_addr_i = 32'h0;
    @(negedge clk_i);
    chk1("flh_ready", if_req_ready_o, 1'b1);
    next_cycle();
    idle();
    if_rsp_ready_i = 1'b0;
    next_cycle();
    @(negedge clk_i);
    chk1("flh_held", if_rsp_valid_o, 1'b1);
    next_cycle();
    if_flush_i = 1'b1; if_rsp_ready_i = 1'b1;
    next_cycle();
    if_flush_i = 1'b0;
    @(negedge clk_i);
    chk1("flh_dropped", if_rsp_valid_o, 1'b0);
    next_cycle();

    // Reset mid-operation, after a DM grant and after an IF grant
    for (int v = 0; v < 2; v++) begin
      if (v == 0) begin dm_req_valid_i = 1'b1; dm_addr_i = 32'h0; end
      else begin if_req_valid_i = 1'b1; if_addr_i = 32'h0; end
      @(negedge clk_i);
      if (v == 0) chk1("mr_dm_grant", dm_req_ready_o, 1'b1);
      else chk1("mr_if_grant", if_req_ready_o, 1'b1);
      next_cycle();
      idle();
      rst_i = 1'b1;
      @(negedge clk_i);
      chk1("mr_if_rsp_in_rst", if_rsp_valid_o, 1'b0);
      chk1("mr_dm_rsp_in_rst", dm_rsp_valid_o, 1'b0);
      next_cycle();
      rst_i = 1'b0;
      if_req_valid_i = 1'b1; if_addr_i = 32'h4;
      dm_req_valid_i = 1'b1; dm_addr_i = 32'h8;
      @(negedge clk_i);
      chk1("mr_dm_rsp_after", dm_rsp_valid_o, 1'b0);
      chk1("mr_if_rsp_after", if_rsp_valid_o, 1'b0);
      chk1("mr_tie_if", if_req_ready_o, 1'b1);
      chk1("mr_tie_dm", dm_req_ready_o, 1'b0);
      exp_if.push_back(32'h22);
      next_cycle();
      @(negedge clk_i);
      chk1("mr_next_if", if_req_ready_o, 1'b0);
      chk1("mr_next_dm", dm_req_ready_o, 1'b1);
      exp_dm.push_back(32'h33);
      next_cycle();
      idle();
      next_cycle();
    end

    repeat (2) next_cycle();
    chk32("if_queue_drained", exp_if.size(), 32'h0);
    chk32("dm_queue_drained", exp_dm.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
